// File: rtl/gate2ip_bist_checker_if.sv
// Stimulus/response bundle between the BIST checker and the 2-input gate
// under test, plus the run-control and result signals.
interface gate2ip_bist_checker_if #(
  parameter int unsigned ERRW = 4
);
  logic            start;
  logic            dut_a;
  logic            dut_b;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] err_count;
  logic            first_err_valid;
  logic [1:0]      first_err_vec;

  modport master (
    output start, dut_y,
    input  dut_a, dut_b, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, dut_y,
    output dut_a, dut_b, busy, done, pass, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/gate2ip_bist_checker.sv
// Synthesizable stimulus/response checker for any 2-input gate: sweeps {a,b}
// in Gray order, samples the gate after a settle time and scores it against TRUTH.
module gate2ip_bist_checker #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1,
  parameter int unsigned ERRW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  gate2ip_bist_checker_if.slave  bist
);

  localparam int unsigned WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state;
  logic [1:0]      vec;
  logic [WW-1:0]   wait_cnt;
  logic [PW-1:0]   pass_idx;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [ERRW-1:0] err_q;
  logic            fev_q;
  logic [1:0]      fvec_q;

  logic            mismatch;
  logic [ERRW-1:0] err_next;
  logic            last_vec;

  always_comb begin
    mismatch = (state == S_CHECK) && (bist.dut_y != TRUTH[vec]);
    err_next = err_q;
    if (mismatch && (err_q != '1)) err_next = err_q + ERRW'(1);
    last_vec = (vec == 2'b10) && (pass_idx == PW'(PASSES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      vec      <= '0;
      wait_cnt <= '0;
      pass_idx <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fev_q    <= 1'b0;
      fvec_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bist.start) begin
            state    <= S_SETTLE;
            vec      <= '0;
            wait_cnt <= '0;
            pass_idx <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fvec_q   <= '0;
          end
        end
        S_SETTLE: begin
          if (wait_cnt == WW'(SETTLE - 1)) state <= S_CHECK;
          else wait_cnt <= wait_cnt + WW'(1);
        end
        S_CHECK: begin
          err_q <= err_next;
          if (mismatch && !fev_q) begin
            fev_q  <= 1'b1;
            fvec_q <= vec;
          end
          if (last_vec) begin
            // pass is taken from err_next so the final CHECK's mismatch is counted
            state  <= S_DONE;
            vec    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == '0);
          end else begin
            // Gray step 00->01->11->10->00
            vec      <= {vec[0], ~vec[1]};
            wait_cnt <= '0;
            if (vec == 2'b10) pass_idx <= pass_idx + PW'(1);
            state    <= S_SETTLE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bist.dut_a           = vec[1];
  assign bist.dut_b           = vec[0];
  assign bist.busy            = busy_q;
  assign bist.done            = done_q;
  assign bist.pass            = pass_q;
  assign bist.err_count       = err_q;
  assign bist.first_err_valid = fev_q;
  assign bist.first_err_vec   = fvec_q;

endmodule

// File: tb/tb_gate2ip_bist_checker.sv
// Bench for gate2ip_bist_checker: four parameter sets, a behavioural gate
// with a selectable function, and a sweep-level reference model.
module tb_gate2ip_bist_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = '0;
  logic [3:0] g = 4'b0111;
  int unsigned sel = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gate2ip_bist_checker_if #(.ERRW(4)) b0 ();
  gate2ip_bist_checker_if #(.ERRW(4)) b1 ();
  gate2ip_bist_checker_if #(.ERRW(2)) b2 ();
  gate2ip_bist_checker_if #(.ERRW(4)) b3 ();

  assign b0.start = start_v[0];
  assign b1.start = start_v[1];
  assign b2.start = start_v[2];
  assign b3.start = start_v[3];
  assign b0.dut_y = g[{b0.dut_a, b0.dut_b}];
  assign b1.dut_y = g[{b1.dut_a, b1.dut_b}];
  assign b2.dut_y = g[{b2.dut_a, b2.dut_b}];
  assign b3.dut_y = g[{b3.dut_a, b3.dut_b}];

  gate2ip_bist_checker #(.TRUTH(4'b0111), .SETTLE(2), .PASSES(1), .ERRW(4))
    u0 (.clk(clk), .rst(rst), .bist(b0));
  gate2ip_bist_checker #(.TRUTH(4'b0111), .SETTLE(1), .PASSES(2), .ERRW(4))
    u1 (.clk(clk), .rst(rst), .bist(b1));
  gate2ip_bist_checker #(.TRUTH(4'b0111), .SETTLE(2), .PASSES(2), .ERRW(2))
    u2 (.clk(clk), .rst(rst), .bist(b2));
  gate2ip_bist_checker #(.TRUTH(4'b1000), .SETTLE(3), .PASSES(1), .ERRW(4))
    u3 (.clk(clk), .rst(rst), .bist(b3));

  function automatic int unsigned cfg_settle(int unsigned i);
    case (i) 0: return 2; 1: return 1; 2: return 2; default: return 3; endcase
  endfunction
  function automatic int unsigned cfg_passes(int unsigned i);
    case (i) 0: return 1; 1: return 2; 2: return 2; default: return 1; endcase
  endfunction
  function automatic int unsigned cfg_errw(int unsigned i);
    case (i) 2: return 2; default: return 4; endcase
  endfunction
  function automatic logic [3:0] cfg_truth(int unsigned i);
    case (i) 3: return 4'b1000; default: return 4'b0111; endcase
  endfunction
  function automatic logic [1:0] gray_vec(int unsigned k);
    case (k % 4) 0: return 2'b00; 1: return 2'b01; 2: return 2'b11; default: return 2'b10; endcase
  endfunction

  logic       o_a, o_b, o_busy, o_done, o_pass, o_fev;
  logic [1:0] o_fvec;
  logic [3:0] o_err;

  always_comb begin
    o_a = b0.dut_a; o_b = b0.dut_b; o_busy = b0.busy; o_done = b0.done;
    o_pass = b0.pass; o_fev = b0.first_err_valid; o_fvec = b0.first_err_vec; o_err = b0.err_count;
    case (sel)
      1: begin
        o_a = b1.dut_a; o_b = b1.dut_b; o_busy = b1.busy; o_done = b1.done;
        o_pass = b1.pass; o_fev = b1.first_err_valid; o_fvec = b1.first_err_vec; o_err = b1.err_count;
      end
      2: begin
        o_a = b2.dut_a; o_b = b2.dut_b; o_busy = b2.busy; o_done = b2.done;
        o_pass = b2.pass; o_fev = b2.first_err_valid; o_fvec = b2.first_err_vec;
        o_err = {2'b00, b2.err_count};
      end
      3: begin
        o_a = b3.dut_a; o_b = b3.dut_b; o_busy = b3.busy; o_done = b3.done;
        o_pass = b3.pass; o_fev = b3.first_err_valid; o_fvec = b3.first_err_vec; o_err = b3.err_count;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cfg %0d, t=%0t)", tag, got, exp, sel, $time);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ab"}, {o_a, o_b}, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_fev"}, o_fev, 0);
    check({tag, "_fvec"}, o_fvec, 0);
  endtask

  // One full run on config i with the gate implementing function gf.
  // Called at a negedge; start is sampled at the following rising edge (cycle 0).
  task automatic run(input int unsigned i, input logic [3:0] gf);
    int unsigned s, p, n, errs, maxe;
    bit          fv;
    logic [1:0]  fvec, vv;
    logic [3:0]  t;
    s = cfg_settle(i); p = cfg_passes(i); t = cfg_truth(i);
    n = 4 * p * (s + 1);
    maxe = (1 << cfg_errw(i)) - 1;
    errs = 0; fv = 0; fvec = 2'b00;
    for (int unsigned ps = 0; ps < p; ps++)
      for (int unsigned v = 0; v < 4; v++) begin
        vv = gray_vec(v);
        if (gf[vv] != t[vv]) begin
          if (errs < maxe) errs++;
          if (!fv) begin fv = 1; fvec = vv; end
        end
      end
    sel = i; g = gf;
    start_v[i] = 1'b1;
    for (int unsigned k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k <= n) begin
        check("busy", o_busy, 1);
        check("done_early", o_done, 0);
        check("vec", {o_a, o_b}, gray_vec((k - 1) / (s + 1)));
        if (k == 1) begin
          check("clr_err", o_err, 0);
          check("clr_fev", o_fev, 0);
          check("clr_pass", o_pass, 0);
        end
      end else begin
        check(k == n + 1 ? "done_pulse" : "done_drop", o_done, (k == n + 1) ? 1 : 0);
        check("busy_end", o_busy, 0);
        check("ab_end", {o_a, o_b}, 0);
        check("pass", o_pass, (errs == 0) ? 1 : 0);
        check("err_count", o_err, errs);
        check("first_err_valid", o_fev, fv);
        if (fv) check("first_err_vec", o_fvec, fvec);
      end
      // Random start activity while busy or in DONE must be ignored
      start_v[i] = (k <= n + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      sel = i;
      #1;
      check_idle_zero("reset");
    end
    rst = 1'b0;
    @(negedge clk);

    run(0, 4'b0111);   // correct NAND
    run(0, 4'b1000);   // AND against NAND table
    run(0, 4'b1111);   // stuck-at-1
    run(1, 4'b0000);   // stuck-at-0, two passes, short settle
    run(2, 4'b1000);   // saturating 2-bit counter
    run(3, 4'b1000);   // AND table, correct AND gate

    // Reset mid-run with start held high
    sel = 0; g = 4'b0111;
    start_v[0] = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) begin
        check_idle_zero("midrst");
        rst = 1'b0;
        start_v[0] = 1'b0;
      end else if (k > 6) begin
        check("midrst_nodone", o_done, 0);
        check("midrst_idle", o_busy, 0);
      end
      if (k == 5) rst = 1'b1;
    end
    run(0, 4'b0111);

    for (int unsigned r = 0; r < 24; r++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      run($urandom_range(0, 3), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
